reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Parametrised reset/clock-qualification controller for the SoC top level. Synchronises the raw board reset and MMCM
//  lock, stretches reset, then releases NUM_DOMAINS downstream resets (core, vector coprocessor, protocol controllers, ...)
//  in fixed staggered order. Re-sequences on lock loss or software request; reports the cause of the last reset.
// PARAMETERS
//  NUM_DOMAINS    3   number of reset domains, 1..8; domain 0 released first
//  SYNC_STAGES    2   flop depth of the rst-deassert and locked synchronisers, >=2
//  LOCK_FILTER    4   consecutive synced-locked-high cycles required before stretch, >=1
//  STRETCH_CYCLES 16  cycles all domains stay asserted after lock qualifies, >=1
//  STAGGER_CYCLES 8   cycles between successive domain releases, >=1
//  WDT_CYCLES     1024 watchdog timeout, only used with RST_SEQ_WDT_EN
// PORTS
//  clk          in   1            system clock (buffered MMCM output)
//  rst          in   1            asynchronous, active-high raw reset
//  pll_locked   in   1            MMCM locked, asynchronous to clk
//  sw_rst_req   in   1            single-cycle software reset request, clk domain
//  wdt_kick     in   1            watchdog kick pulse (ignored without RST_SEQ_WDT_EN)
//  domain_nrst  out  NUM_DOMAINS  per-domain active-low reset, registered
//  all_ready    out  1            high when every domain released
//  rst_cause    out  2            last cause: 0 POR/rst, 1 lock loss, 2 software, 3 watchdog
//  seq_state    out  3            current FSM state, debug
// BEHAVIOUR
//  - rst assertion: immediately (async) clears all state; domain_nrst=0, all_ready=0, rst_cause=0, seq_state=HOLD.
//  - rst deassertion synchronised through SYNC_STAGES flops; pll_locked through a separate SYNC_STAGES chain (locked_s).
//  - FSM: HOLD -> WAIT_LOCK -> STRETCH -> RELEASE -> RUN.
//    HOLD: while synced reset active. WAIT_LOCK: count consecutive locked_s=1, any 0 clears count; at LOCK_FILTER -> STRETCH.
//    STRETCH: count STRETCH_CYCLES, then set domain_nrst[0]=1 and enter RELEASE.
//    RELEASE: domain_nrst[i] rises i*STAGGER_CYCLES cycles after domain 0; released bits stay high; after last -> RUN.
//    RUN: all_ready=1 (registered, rises on same edge as domain_nrst[NUM_DOMAINS-1]).
//  - Timing requirement (locked stable high): domain_nrst[0] rises on edge SYNC_STAGES+LOCK_FILTER+STRETCH_CYCLES after
//    rst falls; NUM_DOMAINS=1 -> all_ready rises with it.
//  - Lock loss: locked_s=0 in STRETCH/RELEASE/RUN -> next edge all domain_nrst=0, all_ready=0, rst_cause=1, WAIT_LOCK.
//    Lock loss in WAIT_LOCK only clears the filter count; rst_cause unchanged.
//  - sw_rst_req: honoured only in RUN -> next edge all domains asserted, all_ready=0, rst_cause=2, STRETCH (counter
//    restarted). Ignored in all other states (not queued).
//  - Simultaneous events priority: rst > lock loss > watchdog > sw_rst_req.
//  - Counters sized $clog2 of max(param)+1; no wrap: each saturates/clears on state exit.
//  - domain_nrst only drives low in reset; never glitches high outside the defined release edges.
// CONFIGURATION
//  RST_SEQ_WDT_EN defined: counter runs in RUN only, cleared by wdt_kick and on RUN entry; reaching WDT_CYCLES-1
//    without kick -> same action as sw_rst_req with rst_cause=3. Kick and timeout same cycle: kick wins.
//  RST_SEQ_WDT_EN undefined: no watchdog logic, wdt_kick unused, rst_cause never 3.
// STRUCTURE
//  - Shared header rst_seq.vh: FSM state encodings (HOLD=0,WAIT_LOCK=1,STRETCH=2,RELEASE=3,RUN=4) and RST_CAUSE_* codes.
//  - One sub-module: bit_sync (parameter STAGES, async-clear-to-value) instanced for rst deassert and pll_locked.
// TESTING (defaults unless stated)
//  - rst 1->0, pll_locked=1 throughout -> domain_nrst 3'b001 at edge 22, 3'b011 at 30, 3'b111 + all_ready at 38, cause 0.
//  - pll_locked toggles 1,1,0 then held 1 -> filter restarts; release delayed by exactly the lost cycles.
//  - in RUN, pll_locked=0 -> domain_nrst=0 by edge 3 after fall, cause 1; relock -> full re-sequence.
//  - in RUN, sw_rst_req pulse -> next edge all 0, cause 2; domain 0 back after 16 cycles; pulse in RELEASE ignored.
//  - rst asserted mid-RELEASE -> all outputs reset values same cycle (async, checked before next edge).
//  - RST_SEQ_WDT_EN, WDT_CYCLES=64: no kick -> reset at RUN+64, cause 3; kick every 50 -> never fires.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings, reset-cause codes, sizing helper.
package reset_sequencer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STRETCH   = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } seq_state_t;

  localparam logic [CAUSE_W-1:0] RST_CAUSE_POR  = 2'd0;
  localparam logic [CAUSE_W-1:0] RST_CAUSE_LOCK = 2'd1;
  localparam logic [CAUSE_W-1:0] RST_CAUSE_SW   = 2'd2;
  localparam logic [CAUSE_W-1:0] RST_CAUSE_WDT  = 2'd3;

  // Largest of three cycle counts; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_bit_sync.sv
// Multi-flop synchroniser with asynchronous clear to a chosen value.
module bit_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        CLR_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift chain; clear forces every stage to CLR_VAL immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) chain <= {STAGES{CLR_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset/clock-qualification sequencer: synchronises rst and pll_locked, filters lock,
// stretches reset, then releases NUM_DOMAINS resets in staggered order.
// Optional watchdog re-sequencing is built when RST_SEQ_WDT_EN is defined.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = 3,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned LOCK_FILTER    = 4,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned WDT_CYCLES     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   sw_rst_req,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] domain_nrst,
  output logic                   all_ready,
  output logic [CAUSE_W-1:0]     rst_cause,
  output logic [STATE_W-1:0]     seq_state
);

  localparam int unsigned ND    = NUM_DOMAINS;
  localparam int unsigned CNT_W = $clog2(max3(LOCK_FILTER, STRETCH_CYCLES, STAGGER_CYCLES) + 1);
  localparam int unsigned IDX_W = $clog2(NUM_DOMAINS + 1);
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

  logic rst_s;
  logic locked_s;
  logic wdt_fire;

  seq_state_t       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [IDX_W-1:0] idx, nxt_idx;
  logic [ND-1:0]    nxt_nrst;
  logic             nxt_ready;
  logic [CAUSE_W-1:0] nxt_cause;

  bit_sync #(.STAGES(SYNC_STAGES), .CLR_VAL(1'b1)) u_rst_sync (
    .clk (clk),
    .clr (rst),
    .d   (1'b0),
    .q   (rst_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES), .CLR_VAL(1'b0)) u_lock_sync (
    .clk (clk),
    .clr (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

`ifdef RST_SEQ_WDT_EN
  logic [WDT_W-1:0] wdt_cnt;

  assign wdt_fire = (state == ST_RUN) && !wdt_kick && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

  // Watchdog counts RUN cycles only; zero outside RUN so it starts fresh on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          wdt_cnt <= '0;
    else if (state != ST_RUN || wdt_kick || wdt_fire) wdt_cnt <= '0;
    else                                              wdt_cnt <= wdt_cnt + WDT_W'(1);
  end
`else
  logic [WDT_W-1:0] unused_wdt_cfg;
  logic             unused_wdt_kick;

  assign wdt_fire        = 1'b0;
  assign unused_wdt_cfg  = WDT_W'(WDT_CYCLES);
  assign unused_wdt_kick = wdt_kick;
`endif

  // Next-state and registered-output logic; lock loss outranks watchdog, which outranks software.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    nxt_nrst  = domain_nrst;
    nxt_ready = all_ready;
    nxt_cause = rst_cause;

    if ((state inside {ST_STRETCH, ST_RELEASE, ST_RUN}) && !locked_s) begin
      nxt_state = ST_WAIT_LOCK;
      nxt_cnt   = '0;
      nxt_idx   = '0;
      nxt_nrst  = '0;
      nxt_ready = 1'b0;
      nxt_cause = RST_CAUSE_LOCK;
    end else if (state == ST_RUN && (wdt_fire || sw_rst_req)) begin
      nxt_state = ST_STRETCH;
      nxt_cnt   = '0;
      nxt_idx   = '0;
      nxt_nrst  = '0;
      nxt_ready = 1'b0;
      nxt_cause = wdt_fire ? RST_CAUSE_WDT : RST_CAUSE_SW;
    end else begin
      unique case (state)
        // HOLD samples the lock filter on the first cycle the synced reset is gone.
        ST_HOLD, ST_WAIT_LOCK: begin
          if (!rst_s) begin
            nxt_state = ST_WAIT_LOCK;
            if (!locked_s) begin
              nxt_cnt = '0;
            end else if (cnt == CNT_W'(LOCK_FILTER - 1)) begin
              nxt_state = ST_STRETCH;
              nxt_cnt   = '0;
            end else begin
              nxt_cnt = cnt + CNT_W'(1);
            end
          end
        end
        ST_STRETCH: begin
          if (cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
            nxt_cnt  = '0;
            nxt_nrst = ND'(1);
            if (ND == 1) begin
              nxt_state = ST_RUN;
              nxt_ready = 1'b1;
            end else begin
              nxt_state = ST_RELEASE;
              nxt_idx   = IDX_W'(1);
            end
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
            nxt_cnt  = '0;
            nxt_nrst = domain_nrst | (ND'(1) << idx);
            nxt_idx  = idx + IDX_W'(1);
            if (idx == IDX_W'(ND - 1)) begin
              nxt_state = ST_RUN;
              nxt_ready = 1'b1;
            end
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          nxt_ready = 1'b1;
        end
        default: begin
          nxt_state = ST_HOLD;
          nxt_cnt   = '0;
          nxt_idx   = '0;
          nxt_nrst  = '0;
          nxt_ready = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; rst clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      idx         <= '0;
      domain_nrst <= '0;
      all_ready   <= 1'b0;
      rst_cause   <= RST_CAUSE_POR;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      idx         <= nxt_idx;
      domain_nrst <= nxt_nrst;
      all_ready   <= nxt_ready;
      rst_cause   <= nxt_cause;
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (default parameters, WDT_CYCLES=64).
// Watchdog steps are built when RST_SEQ_WDT_EN is defined.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       wdt_kick;
  logic [2:0] domain_nrst;
  logic       all_ready;
  logic [1:0] rst_cause;
  logic [2:0] seq_state;

  int checks   = 0;
  int failures = 0;

  reset_sequencer #(
    .NUM_DOMAINS    (3),
    .SYNC_STAGES    (2),
    .LOCK_FILTER    (4),
    .STRETCH_CYCLES (16),
    .STAGGER_CYCLES (8),
    .WDT_CYCLES     (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .sw_rst_req  (sw_rst_req),
    .wdt_kick    (wdt_kick),
    .domain_nrst (domain_nrst),
    .all_ready   (all_ready),
    .rst_cause   (rst_cause),
    .seq_state   (seq_state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] nrst, input logic rdy,
                         input logic [1:0] cause, input logic [2:0] st);
    chk({tag, ".nrst"},  32'(domain_nrst), 32'(nrst));
    chk({tag, ".ready"}, 32'(all_ready),   32'(rdy));
    chk({tag, ".cause"}, 32'(rst_cause),   32'(cause));
    chk({tag, ".state"}, 32'(seq_state),   32'(st));
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;
    wdt_kick   = 1'b0;
    tick(3);
    chk_all("por", 3'b000, 1'b0, 2'd0, 3'd0);

    // Nominal bring-up: edges counted from rst deassertion.
    rst = 1'b0;
    tick(21);
    chk_all("nom_e21", 3'b000, 1'b0, 2'd0, 3'd2);
    tick(1);
    chk_all("nom_e22", 3'b001, 1'b0, 2'd0, 3'd3);
    tick(7);
    chk("nom_e29", 32'(domain_nrst), 32'h1);
    tick(1);
    chk("nom_e30", 32'(domain_nrst), 32'h3);
    tick(7);
    chk("nom_e37_rdy", 32'(all_ready), 32'h0);
    tick(1);
    chk_all("nom_e38", 3'b111, 1'b1, 2'd0, 3'd4);

    // Lock glitch during filtering: pll 1,1,0 then 1 -> release at edge 25.
    rst = 1'b1;
    tick(2);
    chk_all("rst2", 3'b000, 1'b0, 2'd0, 3'd0);
    rst = 1'b0;
    pll_locked = 1'b1;
    tick(2);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(21);
    chk("filt_e24", 32'(domain_nrst), 32'h0);
    tick(1);
    chk_all("filt_e25", 3'b001, 1'b0, 2'd0, 3'd3);
    tick(8);
    chk("filt_e33", 32'(domain_nrst), 32'h3);
    tick(8);
    chk_all("filt_e41", 3'b111, 1'b1, 2'd0, 3'd4);

    // Lock loss in RUN: two synchroniser edges, reaction on the third.
    pll_locked = 1'b0;
    tick(2);
    chk("ll_e2", 32'(domain_nrst), 32'h7);
    tick(1);
    chk_all("ll_e3", 3'b000, 1'b0, 2'd1, 3'd1);
    pll_locked = 1'b1;
    tick(21);
    chk_all("relock_e21", 3'b000, 1'b0, 2'd1, 3'd2);
    tick(1);
    chk("relock_e22", 32'(domain_nrst), 32'h1);
    tick(16);
    chk_all("relock_run", 3'b111, 1'b1, 2'd1, 3'd4);

    // Software request in RUN.
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk_all("sw_e1", 3'b000, 1'b0, 2'd2, 3'd2);
    tick(15);
    chk("sw_e16m1", 32'(domain_nrst), 32'h0);
    tick(1);
    chk_all("sw_e16", 3'b001, 1'b0, 2'd2, 3'd3);

    // Software request during RELEASE is dropped.
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk_all("sw_ign", 3'b001, 1'b0, 2'd2, 3'd3);
    tick(6);
    chk("sw_ign_e7", 32'(domain_nrst), 32'h1);
    tick(1);
    chk("sw_ign_e8", 32'(domain_nrst), 32'h3);

    // Asynchronous rst mid-RELEASE: outputs clear before the next edge.
    rst = 1'b1;
    #1;
    chk_all("async_rst", 3'b000, 1'b0, 2'd0, 3'd0);
    tick(1);
    rst = 1'b0;
    tick(38);
    chk_all("rerun", 3'b111, 1'b1, 2'd0, 3'd4);

`ifdef RST_SEQ_WDT_EN
    // No kick: watchdog fires 64 edges after RUN entry.
    tick(63);
    chk_all("wdt_e63", 3'b111, 1'b1, 2'd0, 3'd4);
    tick(1);
    chk_all("wdt_e64", 3'b000, 1'b0, 2'd3, 3'd2);
    tick(16);
    chk("wdt_rel0", 32'(domain_nrst), 32'h1);
    tick(16);
    chk_all("wdt_run", 3'b111, 1'b1, 2'd3, 3'd4);
    // Kick every 50 cycles keeps RUN alive.
    for (int k = 0; k < 4; k++) begin
      tick(49);
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
      chk($sformatf("kick%0d", k), 32'({domain_nrst, all_ready}), 32'hF);
    end
    tick(60);
    chk_all("kick_end", 3'b111, 1'b1, 2'd3, 3'd4);
`else
    // Without the watchdog RUN persists and kicks are ignored.
    tick(100);
    wdt_kick = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    tick(100);
    chk_all("nowdt", 3'b111, 1'b1, 2'd0, 3'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
